// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer with 3-sample majority vote and valid/ack delivery
//
// Purpose:
//   Receive-side sequencer for the UART Rx path. It detects the start bit on the
//   synchronized serial line. It majority-votes three mid-bit samples per bit and
//   shifts in DATA_BITS bits LSB-first. It checks the stop bit and presents each
//   completed word on a level valid / ack handshake. Framing and overrun events are
//   reported as single-cycle pulses. All sequencing advances only on sample_tick, so
//   the FSM is frozen between ticks regardless of gap length.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   sample_tick  in   1-cycle strobe at DIVISION x baud rate
//   rx_in        in   asynchronous serial line, idle high
//   rx_ack       in   consumer takes rx_data this cycle
//   rx_data      out  received word, stable while rx_valid=1
//   rx_valid     out  word available, held until rx_ack
//   frame_err    out  1-cycle pulse: stop-bit vote was 0
//   overrun_err  out  1-cycle pulse: new word delivered over an unacked one
//   busy         out  1 whenever the sequencer is not idle

module uart_rx_ctrl #(
    parameter int DIVISION  = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(DIVISION);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Sample points sit just after the bit centre: MID, MID+1 captured, MID+2 votes.
    localparam logic [TW-1:0] TC_MID  = TW'(DIVISION / 2 - 1);
    localparam logic [TW-1:0] TC_MID1 = TW'(DIVISION / 2);
    localparam logic [TW-1:0] TC_VOTE = TW'(DIVISION / 2 + 1);
    localparam logic [TW-1:0] TC_LAST = TW'(DIVISION - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_sync;
    logic [TW-1:0]          r_tick_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic                   r_cap0;
    logic                   r_cap1;
    logic [DATA_BITS-1:0]   r_shreg;

    logic                   w_rx_s;
    logic                   w_vote;
    logic                   w_vote_tick;
    logic                   w_end_tick;
    logic                   w_deliver;
    logic                   w_frame_bad;
    logic [DATA_BITS-1:0]   w_shift;

    assign w_rx_s      = r_sync[1];
    assign w_vote      = (r_cap0 & r_cap1) | (r_cap0 & w_rx_s) | (r_cap1 & w_rx_s);
    assign w_vote_tick = sample_tick && (r_tick_cnt == TC_VOTE);
    assign w_end_tick  = sample_tick && (r_tick_cnt == TC_LAST);
    // New bit enters at the MSB; after DATA_BITS shifts the first bit lands in bit 0.
    assign w_shift     = (r_shreg >> 1) | (DATA_BITS'(w_vote) << (DATA_BITS - 1));
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_deliver    = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_tick && !w_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // A start bit that votes high was a glitch; abort silently.
                if (w_vote_tick && w_vote) begin
                    w_state_next = S_IDLE;
                end else if (w_end_tick) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_end_tick && (r_bit_cnt == BC_LAST)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Return to idle at the stop vote, half a bit early, so the next
                // start edge is caught even with a slightly fast transmitter.
                if (w_vote_tick) begin
                    if (w_vote) begin
                        w_deliver    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_bad  = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold off restarts until the line has returned high.
                if (sample_tick && w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_cap0      <= 1'b1;
            r_cap1      <= 1'b1;
            r_shreg     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rx_in};
            frame_err   <= w_frame_bad;
            overrun_err <= w_deliver && rx_valid && !rx_ack;

            if (sample_tick) begin
                // The detecting tick counts as 0, so the first START tick is 1.
                if ((w_state_next == S_IDLE) || (r_state == S_BREAK)) begin
                    r_tick_cnt <= '0;
                end else if (r_state == S_IDLE) begin
                    r_tick_cnt <= TW'(1);
                end else if (r_tick_cnt == TC_LAST) begin
                    r_tick_cnt <= '0;
                end else begin
                    r_tick_cnt <= r_tick_cnt + TW'(1);
                end

                if (r_tick_cnt == TC_MID) begin
                    r_cap0 <= w_rx_s;
                end
                if (r_tick_cnt == TC_MID1) begin
                    r_cap1 <= w_rx_s;
                end

                if ((r_state == S_DATA) && (r_tick_cnt == TC_VOTE)) begin
                    r_shreg <= w_shift;
                end

                if (r_state == S_START) begin
                    r_bit_cnt <= '0;
                end else if ((r_state == S_DATA) && (r_tick_cnt == TC_LAST)
                             && (r_bit_cnt != BC_LAST)) begin
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
            end

            // Delivery wins over a same-cycle ack: the new word stays valid.
            if (w_deliver) begin
                rx_data  <= r_shreg;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
